// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback arbiter: requester ids,
// the $0 register constant and the raw writeback request bundle.
package wb_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_ADDR_W = 5;

    localparam logic REQ_ALU  = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rt;
        logic [WB_ADDR_W-1:0] rd;
        logic                 dst_sel;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_dst_mux.sv
// Destination register select: rd when dst_sel is set, rt otherwise.
module wb_dst_mux #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic              dst_sel,
    output logic [ADDR_W-1:0] dst
);

    assign dst = dst_sel ? rd : rt;

endmodule

// File: rtl/wb_port_arbiter.sv
// Two-requester arbiter for the single register-file write port.
// Define WB_ARB_RR_EN for round-robin contests; otherwise the load path always wins.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_rt,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic              req0_dst_sel,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_rt,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic              req1_dst_sel,
    input  logic [DATA_W-1:0] req1_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              grant_id
);

    wb_req_t           req0, req1, gnt_req;
    logic              win_id;
    logic              gnt_id;
    logic              xfer;
    logic              wr_en;
    logic [ADDR_W-1:0] dst;

    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;
    logic              grant_id_q;

    assign req0 = '{rt: req0_rt, rd: req0_rd, dst_sel: req0_dst_sel, data: req0_data};
    assign req1 = '{rt: req1_rt, rd: req1_rd, dst_sel: req1_dst_sel, data: req1_data};

`ifdef WB_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    // Contest goes to whichever requester did not win the previous transfer.
    assign win_id = ~last_grant_q;

    always_comb begin
        last_grant_d = last_grant_q;
        if (xfer) begin
            last_grant_d = gnt_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= REQ_LOAD;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign win_id = REQ_LOAD;
`endif

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n && !flush) begin
            if (req0_valid && req1_valid) begin
                req0_ready = (win_id == REQ_ALU);
                req1_ready = (win_id == REQ_LOAD);
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign xfer    = req0_ready | req1_ready;
    assign gnt_id  = req1_ready ? REQ_LOAD : REQ_ALU;
    assign gnt_req = (gnt_id == REQ_LOAD) ? req1 : req0;

    wb_dst_mux #(
        .ADDR_W (ADDR_W)
    ) u_dst_mux (
        .rt      (gnt_req.rt),
        .rd      (gnt_req.rd),
        .dst_sel (gnt_req.dst_sel),
        .dst     (dst)
    );

    // Writes to $0 are accepted but never reach the register file.
    assign wr_en = xfer && (dst != REG_ZERO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            grant_id_q <= REQ_ALU;
        end else begin
            rf_we_q <= wr_en;
            if (wr_en) begin
                rf_waddr_q <= dst;
                rf_wdata_q <= gnt_req.data;
                grant_id_q <= gnt_id;
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter; expectations follow WB_ARB_RR_EN when defined.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req0_valid, req0_ready, req0_dst_sel;
    logic [4:0]  req0_rt, req0_rd;
    logic [31:0] req0_data;
    logic        req1_valid, req1_ready, req1_dst_sel;
    logic [4:0]  req1_rt, req1_rd;
    logic [31:0] req1_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        grant_id;

    typedef struct {
        int          cyc;
        bit          we;
        logic [4:0]  a;
        logic [31:0] d;
        bit          g;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    bit          m_gid = 1'b0;

    wb_port_arbiter u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_rt      (req0_rt),
        .req0_rd      (req0_rd),
        .req0_dst_sel (req0_dst_sel),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_rt      (req1_rt),
        .req1_rd      (req1_rd),
        .req1_dst_sel (req1_dst_sel),
        .req1_data    (req1_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .grant_id     (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 20000", $time);
        $fatal(1);
    end

    // Expected outputs for the cycle following the next rising edge.
    task automatic push_exp(input bit we, input logic [4:0] a, input logic [31:0] d, input bit g);
        exp_t e;
        if (we) begin
            m_addr = a;
            m_data = d;
            m_gid  = g;
        end
        e.cyc = cyc + 1;
        e.we  = we;
        e.a   = m_addr;
        e.d   = m_data;
        e.g   = m_gid;
        q.push_back(e);
    endtask

    task automatic push_rst();
        m_addr = '0;
        m_data = '0;
        m_gid  = 1'b0;
        push_exp(1'b0, '0, '0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc || rf_we !== e.we || rf_waddr !== e.a || rf_wdata !== e.d
                || grant_id !== e.g) begin
                errors++;
                $display("FAIL out cyc=%0d got we=%b addr=%0d data=%h gid=%b required cyc=%0d we=%b addr=%0d data=%h gid=%b",
                         cyc, rf_we, rf_waddr, rf_wdata, grant_id, e.cyc, e.we, e.a, e.d, e.g);
            end
        end else if (rf_we === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL unexpected_we cyc=%0d got we=1 addr=%0d required we=0", cyc, rf_waddr);
        end
    end

    task automatic test_reset();
        bit first_g;
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_dst_sel = 1'b1; req0_rt = 5'd1; req0_rd = 5'd7;
        req0_data = 32'hAAAA_0007;
        req1_valid = 1'b1; req1_dst_sel = 1'b1; req1_rt = 5'd2; req1_rd = 5'd8;
        req1_data = 32'hBBBB_0008;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready got %b%b required 00", req0_ready, req1_ready);
            end
            push_rst();
            step();
        end
        rst_n = 1'b1;
`ifdef WB_ARB_RR_EN
        first_g = 1'b0;
`else
        first_g = 1'b1;
`endif
        #1;
        checks++;
        if (req0_ready !== !first_g || req1_ready !== first_g) begin
            errors++;
            $display("FAIL first_contest got %b%b required %b%b", req0_ready, req1_ready,
                     !first_g, first_g);
        end
        if (first_g) push_exp(1'b1, 5'd8, 32'hBBBB_0008, 1'b1);
        else         push_exp(1'b1, 5'd7, 32'hAAAA_0007, 1'b0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        push_exp(1'b0, '0, '0, 1'b0);
        step();
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_dst_sel = 1'b1; req0_rt = 5'd2; req0_rd = 5'd9;
        req0_data = 32'h0000_1234;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready got %b%b required 10", req0_ready, req1_ready);
        end
        push_exp(1'b1, 5'd9, 32'h0000_1234, 1'b0);
        step();
        req0_valid = 1'b0;
        push_exp(1'b0, '0, '0, 1'b0);
        step();
    endtask

    task automatic test_zero();
        req1_valid = 1'b1; req1_dst_sel = 1'b0; req1_rt = 5'd0; req1_rd = 5'd5;
        req1_data = 32'h0000_FFFF;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_ready got %b%b required 01", req0_ready, req1_ready);
        end
        push_exp(1'b0, '0, '0, 1'b0);
        step();
        req1_valid = 1'b0;
        push_exp(1'b0, '0, '0, 1'b0);
        step();
    endtask

    task automatic test_contention();
        bit g;
        bit seq_rr[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        req0_valid = 1'b1; req0_dst_sel = 1'b1; req0_rt = 5'd0; req0_rd = 5'd10;
        req0_data = 32'h0000_A0A0;
        req1_valid = 1'b1; req1_dst_sel = 1'b0; req1_rt = 5'd11; req1_rd = 5'd0;
        req1_data = 32'h0000_B1B1;
        for (int i = 0; i < 4; i++) begin
`ifdef WB_ARB_RR_EN
            g = seq_rr[i];
`else
            g = 1'b1;
`endif
            #1;
            checks++;
            if (req0_ready !== !g || req1_ready !== g) begin
                errors++;
                $display("FAIL contention_ready[%0d] got %b%b required %b%b", i, req0_ready,
                         req1_ready, !g, g);
            end
            if (g) push_exp(1'b1, 5'd11, 32'h0000_B1B1, 1'b1);
            else   push_exp(1'b1, 5'd10, 32'h0000_A0A0, 1'b0);
            step();
        end
    endtask

    task automatic test_flush();
        bit g;
        flush = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got %b%b required 00", req0_ready, req1_ready);
        end
        push_exp(1'b0, '0, '0, 1'b0);
        step();
        flush = 1'b0;
`ifdef WB_ARB_RR_EN
        g = 1'b0;
`else
        g = 1'b1;
`endif
        #1;
        checks++;
        if (req0_ready !== !g || req1_ready !== g) begin
            errors++;
            $display("FAIL post_flush_grant got %b%b required %b%b", req0_ready, req1_ready,
                     !g, g);
        end
        if (g) push_exp(1'b1, 5'd11, 32'h0000_B1B1, 1'b1);
        else   push_exp(1'b1, 5'd10, 32'h0000_A0A0, 1'b0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        push_exp(1'b0, '0, '0, 1'b0);
        step();
    endtask

    task automatic test_back_to_back_reset();
        req0_valid = 1'b1; req0_dst_sel = 1'b1; req0_rt = 5'd0; req0_rd = 5'd3;
        req0_data = 32'h0000_0033;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready got %b required 1", req0_ready);
        end
        push_exp(1'b1, 5'd3, 32'h0000_0033, 1'b0);
        step();
        req0_rd = 5'd4;
        req0_data = 32'h0000_0044;
        rst_n = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reset_ready got %b%b required 00", req0_ready, req1_ready);
        end
        push_rst();
        step();
        rst_n = 1'b1;
        req0_valid = 1'b0;
        push_exp(1'b0, '0, '0, 1'b0);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        req0_valid = 1'b0; req0_dst_sel = 1'b0; req0_rt = '0; req0_rd = '0; req0_data = '0;
        req1_valid = 1'b0; req1_dst_sel = 1'b0; req1_rt = '0; req1_rd = '0; req1_data = '0;
        test_reset();
        test_single();
        test_zero();
        test_contention();
        test_flush();
        test_back_to_back_reset();
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries left required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port of the MIPS core between two writeback requesters: the ALU path (req 0) and the load path (req 1). Each requester presents raw rt/rd fields plus a destination-select bit. The block resolves the 5-bit destination through an internal 2:1 destination mux, grants one requester per cycle, and drives a registered write strobe, address and data into the register file. It sits between the execute/memory stages and the register file.

## Interface
- DATA_W, 32, width of write data
- ADDR_W, 5, width of register address
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  pipeline flush; blocks all grants this cycle
- req0_valid  in  1  ALU writeback request
- req0_ready  out  1  ALU request accepted this cycle
- req0_rt, req0_rd  in  ADDR_W  raw register fields
- req0_dst_sel  in  1  0 selects rt, 1 selects rd
- req0_data  in  DATA_W  ALU result
- req1_valid, req1_ready, req1_rt, req1_rd, req1_dst_sel, req1_data  same as req0, for the load path
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  write address
- rf_wdata  out  DATA_W  write data
- grant_id  out  1  requester that produced the current rf_we pulse

## Operation
- A transfer occurs on a rising edge where reqN_valid=1 and reqN_ready=1.
- reqN_ready is combinational from valids, flush and last_grant only. It never depends on output state, because the port accepts one write per cycle.
- With flush=1, both ready signals are 0.
- Only one requester valid: that requester is granted.
- Both valid: arbitration is round-robin. The requester not equal to last_grant is granted. The losing requester sees ready=0 and must hold valid and its payload stable.
- last_grant updates to the granted id on every transfer, contested or not. It holds otherwise.
- Destination: dst = dst_sel ? rd : rt, computed from the granted requester's fields.
- Register $0: if dst==0, the transfer completes (ready=1) but rf_we stays 0. rf_waddr and rf_wdata hold their previous values.
- Every output is registered.

## Timing
- Latency: transfer at edge N means rf_we=1 during cycle N+1 with the matching rf_waddr, rf_wdata and grant_id. The pulse lasts exactly one cycle unless another transfer occurs at edge N+1.
- Throughput: one write per cycle. Back-to-back transfers give a continuous rf_we.
- Reset (rst_n=0 at an edge) sets rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0 and last_grant=1, so req0 wins the first contest.
- While rst_n=0, both ready signals are 0.
- Reset mid-operation: a pending rf_we pulse is dropped in the following cycle.
- Flush at edge N: no transfer, so rf_we=0 in cycle N+1. A pulse already being driven in cycle N completes. last_grant is unchanged.
- Flush and reset asserted together: reset dominates.

## Configuration
- WB_ARB_RR_EN defined: round-robin arbitration as described.
- WB_ARB_RR_EN undefined: fixed priority, req1 (load) always wins contests. last_grant is not implemented, and grant_id reflects only the winner.
- All other behaviour, latency and reset values are identical in both builds.

## Structure
- Shared package `wb_pkg` holds:
  - REQ_ALU=0 and REQ_LOAD=1 id constants
  - REG_ZERO=5'd0
  - the writeback request struct typedef {rt, rd, dst_sel, data}
- One natural sub-module, `wb_dst_mux`: a 5-bit 2:1 destination mux (rt/rd by dst_sel), instantiated once on the granted request.
- Arbitration, last_grant and the output registers stay in the top level.

## Test plan
- Reset check: rst_n=0 for 2 cycles with both valids high. Required: readies=0, rf_we=0, rf_waddr=0, rf_wdata=0; after release, first contest grants req0.
- Single requester: req0 valid, dst_sel=1, rd=9, data=0x1234 at edge N. Required: rf_we=1, rf_waddr=9, rf_wdata=0x1234, grant_id=0 in cycle N+1 only.
- Contention: both held valid for 4 cycles. Required grant sequence 0,1,0,1 under WB_ARB_RR_EN, and 1,1,1,1 without it; the loser's payload is held.
- $0 suppression: req1 valid, dst_sel=0, rt=0, data=0xFFFF. Required: req1_ready=1, rf_we=0 next cycle, rf_waddr and rf_wdata unchanged.
- Flush: both valid, flush=1 at edge N. Required: both readies 0, rf_we=0 in N+1, and the next grant follows the unchanged last_grant.
- Back-to-back then mid-stream reset: req0 writes r3 then r4 on consecutive edges; rst_n=0 at the second edge. Required: the r3 pulse is seen, no r4 pulse, and all outputs are at reset values.
